// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register file and its writeback arbiter.
package regfile_wb_arbiter_pkg;
    localparam int ADDR_W   = 5;
    localparam int NUMB_N   = 1 << ADDR_W;
    localparam int SIZE_W   = 32;
    localparam int NREQ_N   = 3;
    localparam int ZERO_REG = 0;
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;
    localparam int REQ_HILO = 2;
endpackage

// File: rtl/regfile_wb_arbiter_rr_grant.sv
// Combinational round-robin grant: first valid requester at or after ptr wins.
module rr_grant #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] valid,
    input  logic [PW-1:0]   ptr,
    input  logic            hold,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx,
    output logic            any
);
    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        if (!hold) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (int'(ptr) + k) % NREQ;
                if (!any && valid[j]) begin
                    grant[j] = 1'b1;
                    idx      = PW'(j);
                    any      = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file write port.
// Pending-write scoreboard enabled by REGFILE_WB_SCOREBOARD_EN.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR = ADDR_W,
    parameter int NUMB = 1 << ADDR,
    parameter int SIZE = SIZE_W,
    parameter int NREQ = NREQ_N
) (
    input  logic               Clk,
    input  logic               Clr_n,
    input  logic               Hold,
    input  logic [NREQ-1:0]    Req_Valid,
    input  logic [NREQ*ADDR-1:0] Req_Addr,
    input  logic [NREQ*SIZE-1:0] Req_Data,
    output logic [NREQ-1:0]    Req_Ready,
    output logic               Write_Reg,
    output logic [ADDR-1:0]    W_Addr,
    output logic [SIZE-1:0]    W_Data,
    input  logic               Issue_Valid,
    input  logic [ADDR-1:0]    Issue_Addr,
    input  logic [ADDR-1:0]    R_Addr_A,
    input  logic [ADDR-1:0]    R_Addr_B,
    output logic               Busy_A,
    output logic               Busy_B
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic            gany;
    logic [ADDR-1:0] sel_addr;
    logic [SIZE-1:0] sel_data;
    logic            sel_nz;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            wr_q, wr_d;
    logic [ADDR-1:0] waddr_q, waddr_d;
    logic [SIZE-1:0] wdata_q, wdata_d;

    // Reset masks grants so nothing handshakes while Clr_n is low.
    rr_grant #(.NREQ(NREQ), .PW(PW)) u_rr (
        .valid (Req_Valid),
        .ptr   (ptr_q),
        .hold  (Hold | ~Clr_n),
        .grant (grant),
        .idx   (gidx),
        .any   (gany)
    );

    assign Req_Ready = grant;
    assign sel_addr  = Req_Addr[int'(gidx)*ADDR +: ADDR];
    assign sel_data  = Req_Data[int'(gidx)*SIZE +: SIZE];
    assign sel_nz    = (sel_addr != ADDR'(ZERO_REG));

    always_comb begin
        ptr_d   = ptr_q;
        wr_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (gany) begin
            ptr_d   = (int'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);
            wr_d    = sel_nz;
            waddr_d = sel_addr;
            wdata_d = sel_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Clr_n) begin
            ptr_q   <= '0;
            wr_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            wr_q    <= wr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign Write_Reg = wr_q;
    assign W_Addr    = waddr_q;
    assign W_Data    = wdata_q;

`ifdef REGFILE_WB_SCOREBOARD_EN
    logic [NUMB-1:0] pend_q, pend_d;

    // Issue is applied after the clear so a same-cycle reissue stays pending.
    always_comb begin
        pend_d = pend_q;
        if (gany && sel_nz)
            pend_d[sel_addr] = 1'b0;
        if (Issue_Valid && Issue_Addr != ADDR'(ZERO_REG))
            pend_d[Issue_Addr] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (!Clr_n)
            pend_q <= '0;
        else
            pend_q <= pend_d;
    end

    assign Busy_A = pend_q[R_Addr_A];
    assign Busy_B = pend_q[R_Addr_B];
`else
    logic unused_sb;
    assign unused_sb = ^{Issue_Valid, Issue_Addr, R_Addr_A, R_Addr_B};
    assign Busy_A    = 1'b0;
    assign Busy_B    = 1'b0;
`endif
endmodule
